serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// using a full adder built from two half-adder stages and a registered carry.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a, b, cin presented
//   in_ready   block can accept operands (idle)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  result available on sum/cout
//   out_ready  consumer accepts the result
//   sum        low WIDTH bits of a + b + cin
//   cout       carry out of bit WIDTH-1
//   busy       operation in progress or waiting for hand-off
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] res_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             p, s, c_next;

  // Two half-adder stages: (a,b) -> p, then (p,carry) -> s.
  always_comb begin
    p      = a_sr_q[0] ^ b_sr_q[0];
    s      = p ^ carry_q;
    c_next = (a_sr_q[0] & b_sr_q[0]) | (carry_q & p);
  end

  // New sum bit enters at the top; after WIDTH shifts bit i sits at position i.
  if (WIDTH == 1) begin : g_shift_w1
    assign res_shift = s;
  end else begin : g_shift_wn
    assign res_shift = {s, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c_next;
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready, cin;
  logic [7:0] a, b;
  logic       in_ready, out_valid, busy, cout;
  logic [7:0] sum;

  logic in_valid1, out_ready1, a1, b1, cin1;
  logic in_ready1, out_valid1, busy1, cout1, sum1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
    .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the WIDTH=8 instance: an accepted operation is
  // in flight until handed off; its result (plain a+b+cin) appears 8 edges later.
  int         ecnt = 0;
  int         m_e = 0;
  bit         m_init = 0;
  bit         m_active = 0;
  logic [8:0] m_res = '0;
  logic [7:0] m_sum = '0;
  logic       m_cout = 1'b0;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (rst) begin
      m_init   <= 1;
      m_active <= 0;
      m_sum    <= '0;
      m_cout   <= 1'b0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1;
        m_e      <= ecnt;
        m_res    <= {1'b0, a} + {1'b0, b} + {8'b0, cin};
      end
    end else if (ecnt == m_e + 8) begin
      m_sum  <= m_res[7:0];
      m_cout <= m_res[8];
    end else if (ecnt > m_e + 8 && out_ready) begin
      m_active <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_in_ready", in_ready, !m_active);
      chk("cyc_busy", busy, m_active);
      chk("cyc_out_valid", out_valid, m_active && (ecnt > m_e + 8));
      chk("cyc_sum", sum, m_sum);
      chk("cyc_cout", cout, m_cout);
    end
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input int stall, input logic [7:0] xs, input logic xc,
                        input string nm);
    int lat;
    bit ir_seen;
    @(posedge clk); #2;
    a = ta; b = tbv; cin = tc; in_valid = 1; out_ready = (stall == 0);
    @(posedge clk); #2;
    in_valid = 0;
    lat = 0;
    ir_seen = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) ir_seen = 1;
      @(posedge clk); #2;
      lat++;
    end
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_sum"}, sum, xs);
    chk({nm, "_cout"}, cout, xc);
    chk({nm, "_in_ready_low"}, ir_seen, 0);
    if (stall > 0) begin
      in_valid = 1;
      a = 8'hAA;
      repeat (stall) begin
        @(posedge clk); #2;
        chk({nm, "_stall_valid"}, out_valid, 1);
        chk({nm, "_stall_sum"}, sum, xs);
        chk({nm, "_stall_cout"}, cout, xc);
        chk({nm, "_stall_busy"}, busy, 1);
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk); #2;
      chk({nm, "_release_ready"}, in_ready, 1);
      chk({nm, "_release_valid"}, out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w1_tab [8];
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] x;
    int         k, prev, now;
    bit         seen;

    w1_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1; in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0;
    in_valid1 = 0; out_ready1 = 1; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 8'h96, 1'b0, "op_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "op_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, "op_ff_ff_c");
    run_op(8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, "op_00_00_c");
    run_op(8'h12, 8'h34, 1'b0, 5, 8'h46, 1'b0, "op_backpressure");

    // Abort an operation after three bits.
    @(posedge clk); #2;
    a = 8'h80; b = 8'h80; cin = 0; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #2;
    rst = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (out_valid) seen = 1;
    end
    chk("abort_no_valid", seen, 0);
    run_op(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, "op_after_abort");

    // Back-to-back with in_valid and out_ready tied high.
    in_valid = 1;
    out_ready = 1;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (!in_ready && k < 50) begin
        @(posedge clk); #2;
        k++;
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
      x = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      @(posedge clk); #2;
      k = 0;
      while (!out_valid && k < 50) begin
        @(posedge clk); #2;
        k++;
      end
      now = ecnt;
      chk("b2b_sum", sum, x[7:0]);
      chk("b2b_cout", cout, x[8]);
      if (i > 0) chk("b2b_spacing", now - prev, 10);
      prev = now;
    end
    in_valid = 0;

    // WIDTH=1 instance: full-adder truth table, one RUN edge.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; in_valid1 = 1;
      @(posedge clk); #2;
      in_valid1 = 0;
      chk("w1_valid_early", out_valid1, 0);
      @(posedge clk); #2;
      chk("w1_valid", out_valid1, 1);
      chk("w1_sum", sum1, w1_tab[i][0]);
      chk("w1_cout", cout1, w1_tab[i][1]);
    end
    @(posedge clk); #2;
    chk("w1_idle", in_ready1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
